// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared definitions for the banked APB slave memory.
//   state_e      - access FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   CNT_W        - wait-state counter width (WAIT_CYCLES 0..15)
//   num_lanes()  - number of byte-enable lanes in a data word
//   even_parity()- even-parity bit of a lane (callers zero-extend to 64 bits)
// Optional feature macro used by the design: MEM_PARITY_EN.
package apb_mem_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic int unsigned num_lanes(input int unsigned data_w,
                                            input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

  // Zero-extension does not change the XOR reduction, so one fixed width
  // covers every lane width up to 64 bits.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/apb_mem_lane.sv
// apb_mem_lane: one LANE_WIDTH x DEPTH storage lane with registered read.
// Ports:
//   clk      - clock
//   we_i     - write strobe (single access edge)
//   re_i     - read strobe, captures the addressed entry into rdata_o
//   addr_i   - entry index (already range checked by the parent)
//   wdata_i  - lane write data
//   rdata_o  - registered lane read data
//   perr_o   - registered parity mismatch of the last read
// With MEM_PARITY_EN defined one even-parity bit is stored per entry;
// otherwise perr_o is tied low. Contents are not reset.
module apb_mem_lane
  import apb_mem_pkg::*;
#(
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned IW         = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [IW-1:0]         addr_i,
  input  logic [LANE_WIDTH-1:0] wdata_i,
  output logic [LANE_WIDTH-1:0] rdata_o,
  output logic                  perr_o
);

  logic [LANE_WIDTH-1:0] mem_q [DEPTH];
  logic [LANE_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

`ifdef MEM_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q;

  always_ff @(posedge clk) begin
    if (we_i) par_q[addr_i] <= even_parity(64'(wdata_i));
    if (re_i) perr_q <= even_parity(64'(mem_q[addr_i])) ^ par_q[addr_i];
  end

  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/apb_mem_banked.sv
// apb_mem_banked: lane-organised RAM behind a request/ready handshake with
// programmable wait states, registered read data and out-of-range error.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   mem_req       - access request, held with all inputs until mem_ready
//   mem_wr        - 1 = write, 0 = read
//   mem_address   - word address
//   mem_be        - lane write enables (ignored on reads)
//   mem_data_in   - write data
//   mem_ready     - one-cycle completion pulse
//   mem_data_out  - read data while mem_ready on a good read, else 0
//   mem_err       - out-of-range (or parity, with MEM_PARITY_EN) error
// Optional feature macro: MEM_PARITY_EN (per-lane parity storage/check).
module apb_mem_banked
  import apb_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LANE_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                mem_req,
  input  logic                                mem_wr,
  input  logic [ADDR_WIDTH-1:0]               mem_address,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]    mem_be,
  input  logic [DATA_WIDTH-1:0]               mem_data_in,
  output logic                                mem_ready,
  output logic [DATA_WIDTH-1:0]               mem_data_out,
  output logic                                mem_err
);

  localparam int unsigned NL = num_lanes(DATA_WIDTH, LANE_WIDTH);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  latch_en;
  logic                  access;

  logic                  wr_q;
  logic [IW-1:0]         addr_q;
  logic [NL-1:0]         be_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] rdata;
  logic [NL-1:0]         perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    latch_en = 1'b0;
    access   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          latch_en = 1'b1;
          if ({1'b0, mem_address} >= DEPTH_L) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch: only the index bits are kept; the range check is done
  // on the full incoming address before latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (latch_en) begin
      wr_q    <= mem_wr;
      addr_q  <= mem_address[IW-1:0];
      be_q    <= mem_be;
      wdata_q <= mem_data_in;
    end
  end

  for (genvar k = 0; k < NL; k++) begin : g_lane
    apb_mem_lane #(
      .LANE_WIDTH (LANE_WIDTH),
      .DEPTH      (DEPTH),
      .IW         (IW)
    ) u_lane (
      .clk     (clk),
      .we_i    (access & wr_q & be_q[k]),
      .re_i    (access & ~wr_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q[k*LANE_WIDTH +: LANE_WIDTH]),
      .rdata_o (rdata[k*LANE_WIDTH +: LANE_WIDTH]),
      .perr_o  (perr[k])
    );
  end

  // Outputs derive from the state register so reset clears them at once.
  assign mem_ready    = (state_q == ST_RESP);
  assign mem_data_out = (mem_ready && !wr_q && !err_q) ? rdata : '0;
  assign mem_err      = mem_ready && (err_q || (!wr_q && (|perr)));

endmodule

// File: tb/tb_apb_mem_banked.sv
// Scoreboard bench for apb_mem_banked: the driver pushes the expected
// response (data, error, completion cycle) computed from a word-array model;
// an independent negedge monitor pops and compares on every mem_ready.
module tb_apb_mem_banked;

  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WS    = 2;
  localparam int unsigned NL    = DW / LW;

  logic          clk;
  logic          rst_n;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_address;
  logic [NL-1:0] mem_be;
  logic [DW-1:0] mem_data_in;
  logic          mem_ready;
  logic [DW-1:0] mem_data_out;
  logic          mem_err;

  apb_mem_banked #(
    .DATA_WIDTH  (DW),
    .LANE_WIDTH  (LW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_address  (mem_address),
    .mem_be       (mem_be),
    .mem_data_in  (mem_data_in),
    .mem_ready    (mem_ready),
    .mem_data_out (mem_data_out),
    .mem_err      (mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            tests = 0;
  int            fails = 0;
  int            last_ready_cyc = 0;

  task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h required %08h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic chkint(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: mem_ready is observed at the negedge after it rises, which is
  // one edge before the DUT-side sampling edge the latency is quoted at.
  always @(negedge clk) begin
    if (mem_ready) begin
      if (sb.size() == 0) begin
        chk1("unexpected_ready", mem_ready, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk32("rd_data", mem_data_out, e.data);
        chk1("err", mem_err, e.err);
        chkint("ready_cycle", cyc, e.cyc);
      end
    end else begin
      chk32("idle_data", mem_data_out, '0);
      chk1("idle_err", mem_err, 1'b0);
    end
  end

  task automatic xfer(input logic wr, input int unsigned a, input logic [NL-1:0] be,
                      input logic [DW-1:0] d, input logic perr_exp);
    exp_t e;
    bit   got;
    bit   in_range;
    in_range = (a < DEPTH);
    if (!in_range) begin
      e.data = '0;
      e.err  = 1'b1;
    end else if (wr) begin
      e.data = '0;
      e.err  = 1'b0;
      for (int k = 0; k < NL; k++)
        if (be[k]) model[a][k*LW +: LW] = d[k*LW +: LW];
    end else begin
      e.data = model[a];
      e.err  = perr_exp;
    end
    @(negedge clk);
    #1;
    // Sampling edge is the next posedge (cyc+1); good accesses complete
    // WS+1 edges after it, errors at that same edge.
    e.cyc = cyc + 1 + (in_range ? int'(WS) + 1 : 0);
    mem_req     = 1'b1;
    mem_wr      = wr;
    mem_address = AW'(a);
    mem_be      = be;
    mem_data_in = d;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        got = 1'b1;
        break;
      end
    end
    last_ready_cyc = cyc;
    mem_req = 1'b0;
    if (!got) begin
      chk1("ready_timeout", 1'b0, 1'b1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  task automatic wr_word(input int unsigned a, input logic [NL-1:0] be, input logic [DW-1:0] d);
    xfer(1'b1, a, be, d, 1'b0);
  endtask

  task automatic rd_word(input int unsigned a);
    xfer(1'b0, a, '0, $urandom, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int prev;
    rst_n       = 1'b0;
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_address = '0;
    mem_be      = '0;
    mem_data_in = '0;
    repeat (3) @(negedge clk);
    chk1("reset_ready", mem_ready, 1'b0);
    chk32("reset_data", mem_data_out, '0);
    chk1("reset_err", mem_err, 1'b0);
    rst_n = 1'b1;

    for (int unsigned a = 0; a < DEPTH; a++) wr_word(a, '1, $urandom);

    wr_word(5, 4'hF, 32'hDEADBEEF);
    rd_word(5);
    wr_word(5, 4'b0101, 32'h11223344);
    rd_word(5);

    rd_word(20);
    wr_word(20, 4'hF, 32'hCAFEF00D);
    rd_word(4);

    wr_word(6, 4'h0, 32'h12345678);
    rd_word(6);

    // Back-to-back: each completion must follow the previous by WS+3 cycles.
    prev = -1;
    for (int unsigned a = 0; a < 8; a++) begin
      wr_word(a, '1, $urandom);
      if (prev >= 0) chkint("b2b_period", last_ready_cyc - prev, int'(WS) + 3);
      prev = last_ready_cyc;
    end
    for (int unsigned a = 0; a < 8; a++) rd_word(a);

    // Reset during the wait phase of a write: write is lost, outputs clear.
    @(negedge clk);
    #1;
    mem_req     = 1'b1;
    mem_wr      = 1'b1;
    mem_address = AW'(3);
    mem_be      = '1;
    mem_data_in = ~model[3];
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("abort_ready", mem_ready, 1'b0);
    chk32("abort_data", mem_data_out, '0);
    chk1("abort_err", mem_err, 1'b0);
    mem_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_word(3);

`ifdef MEM_PARITY_EN
    wr_word(9, '1, 32'h000000FF);
    dut.g_lane[0].u_lane.mem_q[9] = 8'hFE;
    model[9] = 32'h000000FE;
    xfer(1'b0, 9, '0, '0, 1'b1);
    wr_word(9, '1, $urandom);
    rd_word(9);
`endif

    for (int i = 0; i < 80; i++)
      xfer(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH + 7),
           NL'($urandom), $urandom, 1'b0);

    repeat (5) @(negedge clk);
    chkint("queue_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_mem_banked.md
# apb_mem_banked

Parametrised successor to the byte-lane APB slave memory: a lane-organised RAM with a request/ready handshake, programmable wait states, registered read data and out-of-range error response. Sits behind the APB slave interface logic of the APB-to-APB bridge and replaces the zero-wait combinational-read memory for configurations needing wider data, deeper arrays or slower timing.

## Interface
- DATA_WIDTH, 32: word width; multiple of LANE_WIDTH.
- LANE_WIDTH, 8: bits per byte-enable lane.
- ADDR_WIDTH, 8: word-address width.
- DEPTH, 256: implemented words; DEPTH ≤ 2**ADDR_WIDTH.
- WAIT_CYCLES, 0: wait states inserted before the access completes (0..15).
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- mem_req  input  1  access request; held stable with all other inputs until mem_ready.
- mem_wr  input  1  1 = write, 0 = read.
- mem_address  input  ADDR_WIDTH  word address.
- mem_be  input  DATA_WIDTH/LANE_WIDTH  lane write enables (ignored on reads).
- mem_data_in  input  DATA_WIDTH  write data.
- mem_ready  output  1  one-cycle completion pulse.
- mem_data_out  output  DATA_WIDTH  read data, valid only with mem_ready on a read; otherwise 0.
- mem_err  output  1  error flag, valid only with mem_ready.

## Operation
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE: on mem_req=1, latch command; if mem_address ≥ DEPTH go RESP with error set; else load wait counter with WAIT_CYCLES, go WAIT.
- WAIT: counter decrements each cycle; at 0 the access executes at that edge and FSM goes RESP.
- Write: each lane k with mem_be[k]=1 updates bits [LANE_WIDTH*k +: LANE_WIDTH]; other lanes unchanged; mem_be=0 completes normally with no change.
- Read: full word captured into output register at access edge.
- RESP: mem_ready=1 for exactly one cycle, then IDLE. Errored access never writes; read data 0.
- mem_req low in IDLE: no state change. Inputs changed during WAIT are ignored (latched copy used).
- Array contents are not reset; zero-initialised for simulation.

## Timing
- Reset: FSM IDLE, counter 0, mem_ready 0, mem_data_out 0, mem_err 0; asserting rst_n low mid-access aborts it asynchronously — a write not yet at its access edge is lost, completed writes persist.
- Latency: mem_ready asserts WAIT_CYCLES+2 cycles after the edge sampling mem_req (error: 1 cycle after sampling).
- Throughput: next request sampled first cycle after RESP; back-to-back accesses every WAIT_CYCLES+3 cycles.
- Read after write to same address: returns new data (write completed before next request sampled).

## Configuration
- MEM_PARITY_EN defined: one even-parity bit stored per lane, computed on write; on read each enabled... all lanes checked; any mismatch sets mem_err with mem_ready, data still returned. Partial writes update parity only for written lanes. A parity inject input is not provided; bench forces array bits.
- Undefined: no parity storage; mem_err only for out-of-range addresses.

## Structure
- Package apb_mem_pkg: FSM state enum, NUM_LANES derivation function, counter width constant (4 bits), parity function.
- Sub-module apb_mem_lane: one LANE_WIDTH×DEPTH array (plus parity bit when enabled) with write enable and registered read; instantiated NUM_LANES times via generate.
- Top holds FSM, wait counter, command latch, range check and error merge.

## Test plan
- DATA_WIDTH=32, WAIT_CYCLES=2: write 0xDEADBEEF to addr 5, be=4'hF, then read addr 5 -> 0xDEADBEEF, mem_err=0, mem_ready 4 cycles after request sampled.
- Partial write be=4'b0101 data 0x11223344 over 0xDEADBEEF -> read returns 0xDE22BE44.
- DEPTH=16: read addr 20 -> mem_ready next-but-one cycle, mem_err=1, data 0; write addr 20 then read addr 4 (aliased) unchanged.
- rst_n low during WAIT of write to addr 3 -> outputs 0 immediately, no mem_ready; read addr 3 after reset -> prior value.
- WAIT_CYCLES=0, 8 back-to-back writes then reads addr 0..7 -> each mem_ready exactly 2 cycles after request, one per 3 cycles, data matches.
- MEM_PARITY_EN: write 0x000000FF, force lane0 bit0 flip, read -> mem_err=1, data 0x000000FE.
